// File: rtl/tinynpu_axil_pkg.sv
// Shared types and constants for the tinyNPU AXI4-Lite register block.
package tinynpu_axil_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic {W_IDLE, W_RESP} wr_state_e;
   typedef enum logic {R_IDLE, R_DATA} rd_state_e;

   localparam int REG_CTRL   = 0;
   localparam int REG_STATUS = 1;
   localparam int REG_SRC    = 2;
   localparam int REG_DST    = 3;

endpackage

// File: rtl/tinynpu_axil_wstrb_merge.sv
// Byte-enable merge: each strobe bit selects the new byte, otherwise the old byte is kept.
module tinynpu_axil_wstrb_merge
   import tinynpu_axil_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [DATA_WIDTH-1:0]   old_data,
   input  logic [DATA_WIDTH-1:0]   new_data,
   input  logic [DATA_WIDTH/8-1:0] strb,
   output logic [DATA_WIDTH-1:0]   merged
);

   always_comb begin
      merged = old_data;
      for (int b = 0; b < DATA_WIDTH/8; b++) begin
         if (strb[b]) merged[8*b +: 8] = new_data[8*b +: 8];
      end
   end

endmodule

// File: rtl/tinynpu_axil_regs.sv
// AXI4-Lite responder holding the tinyNPU register file, with flat register
// outputs and per-slot write pulses for the core.
//
// state  | meaning
// W_IDLE | collecting AW and W; commit when both are present
// W_RESP | BVALID held until BREADY
// R_IDLE | ARREADY high, waiting for a read address
// R_DATA | RVALID held until RREADY
module tinynpu_axil_regs
   import tinynpu_axil_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int NUM_REGS   = 4
) (
   input  logic                           S_AXI_ACLK,
   input  logic                           S_AXI_ARESET,
   input  logic [ADDR_WIDTH-1:0]          S_AXI_AWADDR,
   input  logic [2:0]                     S_AXI_AWPROT,
   input  logic                           S_AXI_AWVALID,
   output logic                           S_AXI_AWREADY,
   input  logic [DATA_WIDTH-1:0]          S_AXI_WDATA,
   input  logic [DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
   input  logic                           S_AXI_WVALID,
   output logic                           S_AXI_WREADY,
   output logic [1:0]                     S_AXI_BRESP,
   output logic                           S_AXI_BVALID,
   input  logic                           S_AXI_BREADY,
   input  logic [ADDR_WIDTH-1:0]          S_AXI_ARADDR,
   input  logic [2:0]                     S_AXI_ARPROT,
   input  logic                           S_AXI_ARVALID,
   output logic                           S_AXI_ARREADY,
   output logic [DATA_WIDTH-1:0]          S_AXI_RDATA,
   output logic [1:0]                     S_AXI_RRESP,
   output logic                           S_AXI_RVALID,
   input  logic                           S_AXI_RREADY,
   output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
   output logic [NUM_REGS-1:0]            reg_wr_pulse
);

   localparam int IDX_W  = ADDR_WIDTH - 2;
   localparam int STRB_W = DATA_WIDTH / 8;

   wr_state_e wr_state;
   rd_state_e rd_state;
   logic      ready_en;
   logic      aw_held, w_held;
   logic [IDX_W-1:0]  aw_idx_q;
   logic [DATA_WIDTH-1:0] w_data_q;
   logic [STRB_W-1:0] w_strb_q;
   logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q;

   logic aw_hs, w_hs, ar_hs, commit;
   logic [IDX_W-1:0]  wr_idx, rd_idx;
   logic [DATA_WIDTH-1:0] wr_data, old_word, new_word, rd_word;
   logic [STRB_W-1:0] wr_strb;
   logic [NUM_REGS-1:0] wr_hit;
   logic rd_hit;
   logic unused_ok;

   assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

   // BVALID is only ever high in W_RESP, so the state gates cover it
   assign S_AXI_AWREADY = ready_en && (wr_state == W_IDLE) && !aw_held;
   assign S_AXI_WREADY  = ready_en && (wr_state == W_IDLE) && !w_held;
   assign S_AXI_ARREADY = ready_en && (rd_state == R_IDLE);

   assign aw_hs  = S_AXI_AWVALID && S_AXI_AWREADY;
   assign w_hs   = S_AXI_WVALID && S_AXI_WREADY;
   assign ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;
   assign commit = (wr_state == W_IDLE) && (aw_held || aw_hs) && (w_held || w_hs);

   assign wr_idx  = aw_held ? aw_idx_q : S_AXI_AWADDR[ADDR_WIDTH-1:2];
   assign wr_data = w_held ? w_data_q : S_AXI_WDATA;
   assign wr_strb = w_held ? w_strb_q : S_AXI_WSTRB;
   assign rd_idx  = S_AXI_ARADDR[ADDR_WIDTH-1:2];
   assign reg_q   = regs_q;

   // loop decode avoids indexing the array with a wider-than-needed index
   always_comb begin
      wr_hit   = '0;
      old_word = '0;
      rd_hit   = 1'b0;
      rd_word  = '0;
      for (int k = 0; k < NUM_REGS; k++) begin
         if (wr_idx == IDX_W'(k)) begin
            wr_hit[k] = 1'b1;
            old_word  = regs_q[k];
         end
         if (rd_idx == IDX_W'(k)) begin
            rd_hit  = 1'b1;
            rd_word = regs_q[k];
         end
      end
   end

   tinynpu_axil_wstrb_merge #(.DATA_WIDTH(DATA_WIDTH)) u_merge (
      .old_data (old_word),
      .new_data (wr_data),
      .strb     (wr_strb),
      .merged   (new_word)
   );

   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET) begin
         wr_state     <= W_IDLE;
         rd_state     <= R_IDLE;
         ready_en     <= 1'b0;
         aw_held      <= 1'b0;
         w_held       <= 1'b0;
         aw_idx_q     <= '0;
         w_data_q     <= '0;
         w_strb_q     <= '0;
         regs_q       <= '0;
         reg_wr_pulse <= '0;
         S_AXI_BVALID <= 1'b0;
         S_AXI_BRESP  <= RESP_OKAY;
         S_AXI_RVALID <= 1'b0;
         S_AXI_RDATA  <= '0;
         S_AXI_RRESP  <= RESP_OKAY;
      end else begin
         ready_en     <= 1'b1;
         reg_wr_pulse <= '0;

         case (wr_state)
            W_IDLE: begin
               if (commit) begin
                  for (int k = 0; k < NUM_REGS; k++) begin
                     if (wr_hit[k]) regs_q[k] <= new_word;
                  end
                  reg_wr_pulse <= wr_hit;
                  S_AXI_BRESP  <= (|wr_hit) ? RESP_OKAY : RESP_SLVERR;
                  S_AXI_BVALID <= 1'b1;
                  aw_held      <= 1'b0;
                  w_held       <= 1'b0;
                  wr_state     <= W_RESP;
               end else begin
                  if (aw_hs) begin
                     aw_held  <= 1'b1;
                     aw_idx_q <= S_AXI_AWADDR[ADDR_WIDTH-1:2];
                  end
                  if (w_hs) begin
                     w_held   <= 1'b1;
                     w_data_q <= S_AXI_WDATA;
                     w_strb_q <= S_AXI_WSTRB;
                  end
               end
            end
            W_RESP: begin
               if (S_AXI_BREADY) begin
                  S_AXI_BVALID <= 1'b0;
                  wr_state     <= W_IDLE;
               end
            end
         endcase

         case (rd_state)
            R_IDLE: begin
               if (ar_hs) begin
                  S_AXI_RDATA  <= rd_word;
                  S_AXI_RRESP  <= rd_hit ? RESP_OKAY : RESP_SLVERR;
                  S_AXI_RVALID <= 1'b1;
                  rd_state     <= R_DATA;
               end
            end
            R_DATA: begin
               if (S_AXI_RREADY) begin
                  S_AXI_RVALID <= 1'b0;
                  rd_state     <= R_IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tinynpu_axil_regs.sv
// Directed bench for the tinyNPU AXI4-Lite register block.
module tb_tinynpu_axil_regs;
   import tinynpu_axil_pkg::*;

   localparam int NR = 4;
   localparam int AW = 5;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic [AW-1:0] awaddr, araddr;
   logic          awvalid, awready, wvalid, wready, bvalid, bready;
   logic          arvalid, arready, rvalid, rready;
   logic [31:0]   wdata, rdata;
   logic [3:0]    wstrb;
   logic [1:0]    bresp, rresp;
   logic [NR*32-1:0] reg_q;
   logic [NR-1:0]    reg_wr_pulse;

   tinynpu_axil_regs #(.DATA_WIDTH(32), .ADDR_WIDTH(AW), .NUM_REGS(NR)) dut (
      .S_AXI_ACLK    (clk),
      .S_AXI_ARESET  (rst),
      .S_AXI_AWADDR  (awaddr),
      .S_AXI_AWPROT  (3'b000),
      .S_AXI_AWVALID (awvalid),
      .S_AXI_AWREADY (awready),
      .S_AXI_WDATA   (wdata),
      .S_AXI_WSTRB   (wstrb),
      .S_AXI_WVALID  (wvalid),
      .S_AXI_WREADY  (wready),
      .S_AXI_BRESP   (bresp),
      .S_AXI_BVALID  (bvalid),
      .S_AXI_BREADY  (bready),
      .S_AXI_ARADDR  (araddr),
      .S_AXI_ARPROT  (3'b000),
      .S_AXI_ARVALID (arvalid),
      .S_AXI_ARREADY (arready),
      .S_AXI_RDATA   (rdata),
      .S_AXI_RRESP   (rresp),
      .S_AXI_RVALID  (rvalid),
      .S_AXI_RREADY  (rready),
      .reg_q         (reg_q),
      .reg_wr_pulse  (reg_wr_pulse)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int pulse_cnt [NR];

   initial for (int k = 0; k < NR; k++) pulse_cnt[k] = 0;

   always @(negedge clk) begin
      for (int k = 0; k < NR; k++) if (reg_wr_pulse[k]) pulse_cnt[k] = pulse_cnt[k] + 1;
   end

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic axi_write(input logic [AW-1:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic [1:0] resp);
      bit aw_done, w_done, hs_aw, hs_w;
      int n;
      aw_done = 0; w_done = 0; n = 0;
      awaddr = addr; wdata = data; wstrb = strb;
      awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
      while (!(aw_done && w_done) && n < 20) begin
         hs_aw = awvalid && awready;
         hs_w  = wvalid && wready;
         tick();
         if (hs_aw) begin aw_done = 1; awvalid = 1'b0; end
         if (hs_w)  begin w_done = 1;  wvalid = 1'b0; end
         n++;
      end
      awvalid = 1'b0; wvalid = 1'b0;
      if (!(aw_done && w_done)) chk("wr_handshake_timeout", {aw_done, w_done}, 2'b11);
      n = 0;
      while (!bvalid && n < 20) begin tick(); n++; end
      if (!bvalid) chk("bvalid_timeout", bvalid, 1'b1);
      resp = bresp;
      bready = 1'b1;
      tick();
      bready = 1'b0;
   endtask

   task automatic axi_read(input logic [AW-1:0] addr, output logic [31:0] data,
                           output logic [1:0] resp);
      bit done, hs;
      int n;
      done = 0; n = 0;
      araddr = addr; arvalid = 1'b1; rready = 1'b0;
      while (!done && n < 20) begin
         hs = arvalid && arready;
         tick();
         if (hs) begin done = 1; arvalid = 1'b0; end
         n++;
      end
      arvalid = 1'b0;
      if (!done) chk("ar_handshake_timeout", done, 1'b1);
      n = 0;
      while (!rvalid && n < 20) begin tick(); n++; end
      if (!rvalid) chk("rvalid_timeout", rvalid, 1'b1);
      data = rdata;
      resp = rresp;
      rready = 1'b1;
      tick();
      rready = 1'b0;
   endtask

   logic [1:0]  resp;
   logic [31:0] rd;
   logic [31:0] fill_val [NR];

   initial begin
      rst = 1'b1;
      awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
      awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
      fill_val[0] = 32'h1; fill_val[1] = 32'h2; fill_val[2] = 32'h3; fill_val[3] = 32'h4;

      // reset state
      repeat (3) tick();
      chk("rst_awready", awready, 1'b0);
      chk("rst_wready",  wready,  1'b0);
      chk("rst_arready", arready, 1'b0);
      chk("rst_bvalid",  bvalid,  1'b0);
      chk("rst_reg_q",   reg_q,   128'h0);
      rst = 1'b0;
      tick();
      chk("rel_awready", awready, 1'b1);
      chk("rel_wready",  wready,  1'b1);
      chk("rel_arready", arready, 1'b1);

      // sequential fill and readback
      axi_write(AW'(REG_CTRL*4),   fill_val[0], 4'hF, resp); chk("fill_bresp0", resp, RESP_OKAY);
      axi_write(AW'(REG_STATUS*4), fill_val[1], 4'hF, resp); chk("fill_bresp1", resp, RESP_OKAY);
      axi_write(AW'(REG_SRC*4),    fill_val[2], 4'hF, resp); chk("fill_bresp2", resp, RESP_OKAY);
      axi_write(AW'(REG_DST*4),    fill_val[3], 4'hF, resp); chk("fill_bresp3", resp, RESP_OKAY);
      for (int k = 0; k < NR; k++) begin
         axi_read(AW'(k*4), rd, resp);
         chk($sformatf("fill_rdata%0d", k), rd, fill_val[k]);
         chk($sformatf("fill_rresp%0d", k), resp, RESP_OKAY);
         chk($sformatf("fill_pulse%0d", k), pulse_cnt[k], 1);
      end

      // decoupled AW then W three cycles later
      awaddr = 5'h08; awvalid = 1'b1;
      chk("dec_awready_pre", awready, 1'b1);
      tick();
      awvalid = 1'b0;
      chk("dec_awready_held", awready, 1'b0);
      tick(); tick();
      wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1;
      chk("dec_wready", wready, 1'b1);
      chk("dec_bvalid_pre", bvalid, 1'b0);
      tick();
      wvalid = 1'b0;
      chk("dec_bvalid_post", bvalid, 1'b1);
      chk("dec_reg2", reg_q[95:64], 32'hDEADBEEF);
      chk("dec_pulse", reg_wr_pulse, 4'b0100);
      bready = 1'b1; tick(); bready = 1'b0;
      axi_read(5'h08, rd, resp);
      chk("dec_rdata", rd, 32'hDEADBEEF);

      // byte strobes with B backpressure
      axi_write(5'h00, 32'h11223344, 4'hF, resp);
      awaddr = 5'h00; wdata = 32'hAABBCCDD; wstrb = 4'b0101;
      awvalid = 1'b1; wvalid = 1'b1;
      tick();
      awvalid = 1'b0; wvalid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("bp_bvalid%0d", i),  bvalid,  1'b1);
         chk($sformatf("bp_awready%0d", i), awready, 1'b0);
         chk($sformatf("bp_wready%0d", i),  wready,  1'b0);
         tick();
      end
      chk("bp_bresp", bresp, RESP_OKAY);
      bready = 1'b1; tick(); bready = 1'b0;
      chk("bp_awready_back", awready, 1'b1);
      axi_read(5'h00, rd, resp);
      chk("strb_rdata", rd, 32'h11BB33DD);

      // out-of-range write and read
      axi_write(5'h10, 32'h55, 4'hF, resp);
      chk("oor_bresp", resp, RESP_SLVERR);
      chk("oor_reg_q", reg_q, {32'h4, 32'hDEADBEEF, 32'h2, 32'h11BB33DD});
      chk("oor_pulses", {pulse_cnt[3][7:0], pulse_cnt[2][7:0], pulse_cnt[1][7:0], pulse_cnt[0][7:0]},
          32'h01020103);
      axi_read(5'h1C, rd, resp);
      chk("oor_rresp", resp, RESP_SLVERR);
      chk("oor_rdata", rd, 32'h0);

      // write commit and read of the same slot on one edge
      axi_write(5'h04, 32'h5, 4'hF, resp);
      awaddr = 5'h04; wdata = 32'h9; wstrb = 4'hF; araddr = 5'h04;
      awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
      tick();
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      chk("col_rvalid", rvalid, 1'b1);
      chk("col_rdata", rdata, 32'h5);
      chk("col_bvalid", bvalid, 1'b1);
      chk("col_reg1", reg_q[63:32], 32'h9);
      bready = 1'b1; rready = 1'b1; tick(); bready = 1'b0; rready = 1'b0;
      axi_read(5'h04, rd, resp);
      chk("col_rdata_after", rd, 32'h9);

      // reset with B and R both pending
      awaddr = 5'h0C; wdata = 32'h77; wstrb = 4'hF; araddr = 5'h08;
      awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
      tick();
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      chk("mid_bvalid_pend", bvalid, 1'b1);
      chk("mid_rvalid_pend", rvalid, 1'b1);
      rst = 1'b1;
      tick();
      chk("mid_bvalid", bvalid, 1'b0);
      chk("mid_rvalid", rvalid, 1'b0);
      chk("mid_reg_q", reg_q, 128'h0);
      chk("mid_awready", awready, 1'b0);
      rst = 1'b0;
      tick();
      chk("mid_rel_awready", awready, 1'b1);
      chk("mid_rel_wready",  wready,  1'b1);
      chk("mid_rel_arready", arready, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
